conv_frame_reader: RTL and testbench

Raster-order pixel source for the convolution datapath. On a start pulse it latches the frame geometry, reads the frame from a synchronous-read pixel memory at consecutive addresses, and emits one pixel per transfer on a pixel/valid stream. That stream is exactly what the CNN top consumes on in_point/valid_in; frame_column_size/frame_row_size go to the CNN unchanged.

---
 rtl/conv_frame_reader.sv | 213 +++++++++++++++++++++
 tb/tb_conv_frame_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_reader.sv
// conv_frame_reader: raster-order pixel source for the convolution datapath.
// On an accepted start it latches the frame geometry, issues one read per
// pixel to a synchronous-read memory (optionally spaced by idle cycles) and
// re-times the returned data into a pixel/valid stream tagged with
// end-of-row and end-of-frame markers.
module conv_frame_reader #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000,
    parameter int ADDR_WIDTH    = 22,
    localparam int DIM_W        = $clog2(BUFFER_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DIM_W-1:0]       frame_column_size,
    input  logic [DIM_W-1:0]       frame_row_size,
    input  logic [3:0]             gap_cycles,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
    output logic [PIXEL_WIDTH-1:0] out_point,
    output logic                   out_valid,
    output logic                   out_eol,
    output logic                   out_last,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DIM_W-1:0]        cols_q, cols_d;
    logic [DIM_W-1:0]        rows_q, rows_d;
    logic [3:0]              gap_q, gap_d;
    logic [DIM_W-1:0]        col_q, col_d;
    logic [DIM_W-1:0]        row_q, row_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              gap_cnt_q, gap_cnt_d;
    logic                    drain_cnt_q, drain_cnt_d;

    // Read tags travel one stage alongside the memory latency (_p1),
    // then land in the output register together with the returned pixel.
    logic                    vld_p1_q, vld_p1_d;
    logic                    eol_p1_q, eol_p1_d;
    logic                    last_p1_q, last_p1_d;
    logic [PIXEL_WIDTH-1:0]  out_point_q;
    logic                    out_valid_q, out_valid_d;
    logic                    out_eol_q, out_eol_d;
    logic                    out_last_q, out_last_d;

    logic                    rd_eol;
    logic                    rd_last;
    logic                    kill;

    assign rd_eol  = (col_q == cols_q - DIM_W'(1));
    assign rd_last = rd_eol && (row_q == rows_q - DIM_W'(1));
    // abort only acts on a frame in progress; in IDLE it merely masks start
    assign kill    = abort && (state_q != S_IDLE);

    // Next-state logic: frame sequencing, raster counters and read tags
    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        gap_d       = gap_q;
        col_d       = col_q;
        row_d       = row_q;
        addr_d      = addr_q;
        gap_cnt_d   = gap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        vld_p1_d    = 1'b0;
        eol_p1_d    = 1'b0;
        last_p1_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cols_d      = frame_column_size;
                    rows_d      = frame_row_size;
                    gap_d       = gap_cycles;
                    col_d       = '0;
                    row_d       = '0;
                    addr_d      = '0;
                    gap_cnt_d   = '0;
                    drain_cnt_d = 1'b0;
                    // An empty frame still reports completion, but reads nothing
                    if (frame_column_size == '0 || frame_row_size == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                vld_p1_d  = 1'b1;
                eol_p1_d  = rd_eol;
                last_p1_d = rd_last;
                addr_d    = addr_q + ADDR_WIDTH'(1);
                if (rd_eol) begin
                    col_d = '0;
                    row_d = row_q + DIM_W'(1);
                end else begin
                    col_d = col_q + DIM_W'(1);
                end
                if (rd_last) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 1'b0;
                end else if (gap_q != 4'd0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 4'd1;
                end
            end
            S_GAP: begin
                // gap_cnt_q is the number of idle cycles spent so far, this one included
                if (gap_cnt_q >= gap_q)
                    state_d = S_READ;
                else
                    gap_cnt_d = gap_cnt_q + 4'd1;
            end
            S_DRAIN: begin
                if (drain_cnt_q)
                    state_d = S_DONE;
                else
                    drain_cnt_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d  = S_IDLE;
            vld_p1_d = 1'b0;
        end
    end

    // Output stage qualifiers: cleared by abort so in-flight pixels are dropped
    always_comb begin
        out_valid_d = vld_p1_q;
        out_eol_d   = vld_p1_q && eol_p1_q;
        out_last_d  = vld_p1_q && last_p1_q;
        if (kill) begin
            out_valid_d = 1'b0;
            out_eol_d   = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // State, geometry and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            gap_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            gap_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            gap_q       <= gap_d;
            col_q       <= col_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            gap_cnt_q   <= gap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Two-stage pixel pipeline: tag delay (_p1) then output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            eol_p1_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            out_point_q <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            eol_p1_q    <= eol_p1_d;
            last_p1_q   <= last_p1_d;
            out_point_q <= mem_rd_data;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_last_q  <= out_last_d;
        end
    end

    assign mem_rd_en  = (state_q == S_READ);
    assign mem_addr   = addr_q;
    assign out_point  = out_point_q;
    assign out_valid  = out_valid_q;
    assign out_eol    = out_eol_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_frame_reader.sv
// Directed bench for conv_frame_reader: a table of frame geometries with
// hand-computed timing, plus hand-written abort / restart / reset sequences.
module tb_conv_frame_reader;

    localparam int DIM_W = $clog2(2000);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [DIM_W-1:0] frame_column_size;
    logic [DIM_W-1:0] frame_row_size;
    logic [3:0]       gap_cycles;
    logic             mem_rd_en;
    logic [21:0]      mem_addr;
    logic [7:0]       mem_rd_data = '0;
    logic [7:0]       out_point;
    logic             out_valid;
    logic             out_eol;
    logic             out_last;
    logic             busy;
    logic             frame_done;

    int errors = 0;
    int checks = 0;

    conv_frame_reader #(
        .PIXEL_WIDTH(8),
        .BUFFER_LENGTH(2000),
        .ADDR_WIDTH(22)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .frame_column_size(frame_column_size),
        .frame_row_size(frame_row_size),
        .gap_cycles(gap_cycles),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .out_point(out_point),
        .out_valid(out_valid),
        .out_eol(out_eol),
        .out_last(out_last),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory holding memory[i] = i (low 8 bits)
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    typedef struct {
        int cols;
        int rows;
        int gap;
        int restart_k;   // cycle index at which a spurious start is driven, -1 none
        int npix;
        int first_k;     // cycle index of the first out_valid, -1 none
        int done_k;      // cycle index of frame_done
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},  int'(mem_rd_en),  0);
        check({tag, "_addr"},   int'(mem_addr),   0);
        check({tag, "_point"},  int'(out_point),  0);
        check({tag, "_valid"},  int'(out_valid),  0);
        check({tag, "_eol"},    int'(out_eol),    0);
        check({tag, "_last"},   int'(out_last),   0);
        check({tag, "_busy"},   int'(busy),       0);
        check({tag, "_done"},   int'(frame_done), 0);
    endtask

    // Pulses start for one edge; returns just after that edge (cycle index 0).
    task automatic kick(input int cols, input int rows, input int gap);
        frame_column_size = DIM_W'(cols);
        frame_row_size    = DIM_W'(rows);
        gap_cycles        = 4'(gap);
        start             = 1'b1;
        @(posedge clk); #1;
        start             = 1'b0;
    endtask

    // Runs one frame and checks addresses, pixels, tags, spacing and timing.
    task automatic run_frame(input vec_t v, input string tag);
        int  nreads   = 0;
        int  npix     = 0;
        int  ndone    = 0;
        int  done_k   = -1;
        int  first_k  = -1;
        bit  finished = 1'b0;
        kick(v.cols, v.rows, v.gap);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                start             = 1'b0;
                frame_column_size = DIM_W'(v.cols);
                frame_row_size    = DIM_W'(v.rows);
                gap_cycles        = 4'(v.gap);
            end
            if (mem_rd_en) begin
                check($sformatf("%s_addr%0d", tag, nreads), int'(mem_addr), nreads);
                nreads++;
            end
            if (out_valid) begin
                if (first_k < 0) first_k = k;
                check($sformatf("%s_pix%0d", tag, npix), int'(out_point), npix & 255);
                check($sformatf("%s_eol%0d", tag, npix), int'(out_eol),
                      int'((npix % v.cols) == v.cols - 1));
                check($sformatf("%s_last%0d", tag, npix), int'(out_last),
                      int'(npix == v.npix - 1));
                check($sformatf("%s_slot%0d", tag, npix), k, v.first_k + npix * (v.gap + 1));
                npix++;
            end else begin
                if (out_eol || out_last)
                    check($sformatf("%s_tag_without_valid_k%0d", tag, k), 1, 0);
            end
            if (frame_done) begin
                ndone++;
                done_k = k;
            end
            if (ndone >= 1 && k == done_k + 1)
                check({tag, "_busy_drop"}, int'(busy), 0);
            if (ndone >= 1 && k == done_k + 2) begin
                check({tag, "_stay_idle"}, int'(busy), 0);
                finished = 1'b1;
                break;
            end
            if (k == v.restart_k) begin
                start             = 1'b1;
                frame_column_size = DIM_W'(7);
                frame_row_size    = DIM_W'(7);
                gap_cycles        = 4'(5);
            end
        end
        start = 1'b0;
        check({tag, "_timeout"}, int'(finished), 1);
        check({tag, "_ndone"},   ndone,   1);
        check({tag, "_nreads"},  nreads,  v.npix);
        check({tag, "_npix"},    npix,    v.npix);
        check({tag, "_first_k"}, first_k, v.first_k);
        check({tag, "_done_k"},  done_k,  v.done_k);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int   nval;
        int   ndone;

        tbl[0] = '{4, 3,  0, -1, 12,  2, 14};  // 4x3 streaming, one pixel per clock
        tbl[1] = '{2, 2,  2, -1,  4,  2, 12};  // gap 2: pulses 3 cycles apart
        tbl[2] = '{0, 5,  0, -1,  0, -1,  0};  // zero columns: done only
        tbl[3] = '{3, 1,  1, -1,  3,  2,  7};  // single row, gap 1
        tbl[4] = '{1, 1,  0, -1,  1,  2,  3};  // single pixel
        tbl[5] = '{5, 0,  3, -1,  0, -1,  0};  // zero rows: done only
        tbl[6] = '{1, 4,  0, -1,  4,  2,  6};  // single column: every pixel is eol
        tbl[7] = '{4, 3,  0,  4, 12,  2, 14};  // start mid-frame with new sizes ignored
        tbl[8] = '{2, 2,  0,  6,  4,  2,  6};  // start during DONE ignored
        tbl[9] = '{2, 3, 15, -1,  6,  2, 83};  // maximum gap

        rst               = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        frame_column_size = '0;
        frame_row_size    = '0;
        gap_cycles        = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_frame(tbl[i], $sformatf("vec%0d", i));
        end

        // abort right as the 5th read of an 8x8 frame is issued
        nval  = 0;
        ndone = 0;
        kick(8, 8, 0);
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (out_valid) nval++;
            if (frame_done) ndone++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid_pre", nval, 3);
        check("abort_valid_off", int'(out_valid), 0);
        check("abort_busy_off",  int'(busy), 0);
        check("abort_rd_off",    int'(mem_rd_en), 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) nval++;
            if (frame_done) ndone++;
        end
        check("abort_no_more_valid", nval, 3);
        check("abort_no_done", ndone, 0);
        v = '{2, 2, 0, -1, 4, 2, 6};
        run_frame(v, "post_abort");

        // asynchronous reset in the middle of a frame, held for 2 cycles
        ndone = 0;
        kick(8, 8, 0);
        repeat (5) begin @(posedge clk); #1; end
        check("prerst_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(posedge clk); #1;
        check_all_zero("rst_hold1");
        @(posedge clk); #1;
        check_all_zero("rst_hold2");
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (frame_done || out_valid || busy) ndone++;
        end
        check("rst_quiet_after", ndone, 0);
        v = '{3, 2, 0, -1, 6, 2, 8};
        run_frame(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
